// File: rtl/fp_div_norm_round.sv
// fp_div_norm_round
// Takes the raw quotient produced by a floating-point mantissa divider. It
// normalises the quotient, rounds it to nearest-even, and packs an IEEE-style
// result. Overflow saturates to infinity. Underflow flushes to a signed zero.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   in_valid     raw quotient valid (upstream holds data until in_ready)
//   in_ready     block idle and out of reset, can accept
//   in_sign      result sign
//   in_exp       signed biased exponent (EB+2 bits), leading one at in_mant[W-1]
//   in_mant      raw quotient mantissa (W = 2*MB+3 bits)
//   in_sticky    divider remainder nonzero
//   in_nan/in_inf/in_zero  special-case flags, priority nan > inf > zero
//   out_valid    result valid, held with data until out_ready
//   out_ready    downstream accepts result
//   out_fp       {sign, exponent[EB-1:0], mantissa[MB-1:0]}
//   out_ovf/out_unf/out_inexact  status for out_fp
module fp_div_norm_round #(
    parameter int EB = 8,
    parameter int MB = 23,
    localparam int N = EB + MB + 1,
    localparam int W = 2 * MB + 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EB+1:0]     in_exp,
    input  logic [W-1:0]      in_mant,
    input  logic              in_sticky,
    input  logic              in_nan,
    input  logic              in_inf,
    input  logic              in_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_fp,
    output logic              out_ovf,
    output logic              out_unf,
    output logic              out_inexact
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Largest biased exponent of a finite result, plus one (all-ones = inf).
    localparam logic signed [EB+2:0] EXP_MAX = (EB+3)'((2 ** EB) - 1);

    state_t                 state_r;
    logic                   sign_r;
    logic [EB+1:0]          exp_r;
    logic [W-1:0]           mant_r;
    logic                   sticky_r;

    logic                   is_special_s;
    logic [N-1:0]           special_fp_s;
    logic [MB-1:0]          frac_s;
    logic                   guard_s;
    logic                   sticky_s;
    logic                   round_up_s;
    logic [MB:0]            sum_s;
    logic signed [EB+2:0]   exp_post_s;
    logic                   ovf_s;
    logic                   unf_s;
    logic                   inexact_s;

    // Accept only from IDLE and never while reset is asserted.
    assign in_ready = (state_r == IDLE) && rst_n;

    // Special-case result selection for the captured-in-IDLE fast path.
    always_comb begin
        is_special_s = in_nan | in_inf | in_zero | (in_mant == {W{1'b0}});
        if (in_nan) begin
            special_fp_s = {1'b0, {EB{1'b1}}, 1'b1, {(MB-1){1'b0}}};
        end else if (in_inf) begin
            special_fp_s = {in_sign, {EB{1'b1}}, {MB{1'b0}}};
        end else begin
            special_fp_s = {in_sign, {EB{1'b0}}, {MB{1'b0}}};
        end
    end

    // Round-to-nearest-even on the normalised mantissa plus range checks.
    always_comb begin
        frac_s     = mant_r[W-2 -: MB];
        guard_s    = mant_r[W-2-MB];
        sticky_s   = (|mant_r[W-3-MB:0]) | sticky_r;
        round_up_s = guard_s & (sticky_s | frac_s[0]);
        sum_s      = {1'b0, frac_s} + {{MB{1'b0}}, round_up_s};
        // One extra bit so the carry increment cannot wrap the signed exponent.
        exp_post_s = $signed({exp_r[EB+1], exp_r}) + $signed({{(EB+2){1'b0}}, sum_s[MB]});
        ovf_s      = (exp_post_s >= EXP_MAX);
        unf_s      = exp_post_s[EB+2] | (exp_post_s == {(EB+3){1'b0}});
        inexact_s  = guard_s | sticky_s;
    end

    // Control FSM, datapath registers and registered result/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            sign_r      <= 1'b0;
            exp_r       <= {(EB+2){1'b0}};
            mant_r      <= {W{1'b0}};
            sticky_r    <= 1'b0;
            out_valid   <= 1'b0;
            out_fp      <= {N{1'b0}};
            out_ovf     <= 1'b0;
            out_unf     <= 1'b0;
            out_inexact <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sign_r   <= in_sign;
                        exp_r    <= in_exp;
                        mant_r   <= in_mant;
                        sticky_r <= in_sticky;
                        if (is_special_s) begin
                            out_fp      <= special_fp_s;
                            out_ovf     <= 1'b0;
                            out_unf     <= 1'b0;
                            out_inexact <= 1'b0;
                            out_valid   <= 1'b1;
                            state_r     <= OUT;
                        end else begin
                            state_r <= NORM;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                NORM: begin
                    // One shift per cycle; the cycle that sees the MSB set moves on.
                    if (mant_r[W-1]) begin
                        state_r <= ROUND;
                    end else begin
                        mant_r <= {mant_r[W-2:0], 1'b0};
                        exp_r  <= exp_r - {{(EB+1){1'b0}}, 1'b1};
                    end
                end
                ROUND: begin
                    if (ovf_s) begin
                        out_fp      <= {sign_r, {EB{1'b1}}, {MB{1'b0}}};
                        out_ovf     <= 1'b1;
                        out_unf     <= 1'b0;
                        out_inexact <= 1'b1;
                    end else if (unf_s) begin
                        out_fp      <= {sign_r, {EB{1'b0}}, {MB{1'b0}}};
                        out_ovf     <= 1'b0;
                        out_unf     <= 1'b1;
                        out_inexact <= inexact_s;
                    end else begin
                        // On carry-out sum_s[MB-1:0] is already zero.
                        out_fp      <= {sign_r, exp_post_s[EB-1:0], sum_s[MB-1:0]};
                        out_ovf     <= 1'b0;
                        out_unf     <= 1'b0;
                        out_inexact <= inexact_s;
                    end
                    out_valid <= 1'b1;
                    state_r   <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= OUT;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_norm_round.sv
// Directed self-checking bench for fp_div_norm_round (EB=8, MB=23).
module tb_fp_div_norm_round;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [48:0] in_mant;
    logic        in_sticky;
    logic        in_nan;
    logic        in_inf;
    logic        in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_fp;
    logic        out_ovf;
    logic        out_unf;
    logic        out_inexact;

    int checks = 0;
    int errors = 0;

    // Results captured by run_op.
    logic [31:0] r_fp;
    logic        r_ovf, r_unf, r_inx;
    int          r_lat;
    logic        r_to;
    logic        r_busy_ready;

    localparam logic [48:0] ONE48 = 49'd1;

    always #5 clk = ~clk;

    fp_div_norm_round dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
        .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_fp(out_fp), .out_ovf(out_ovf), .out_unf(out_unf), .out_inexact(out_inexact)
    );

    // Drives one operation, measures latency from accept, optionally releases the result.
    task automatic run_op(input logic s, input logic [9:0] e, input logic [48:0] m,
                          input logic st, input logic nan, input logic inf,
                          input logic zero, input logic release_out);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        in_sign = s; in_exp = e; in_mant = m; in_sticky = st;
        in_nan = nan; in_inf = inf; in_zero = zero;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        r_lat = 1;
        r_busy_ready = 1'b0;
        while (!out_valid && r_lat < 200) begin
            if (in_ready) r_busy_ready = 1'b1;
            @(posedge clk); #1; r_lat++;
        end
        r_to  = !out_valid;
        r_fp  = out_fp;
        r_ovf = out_ovf;
        r_unf = out_unf;
        r_inx = out_inexact;
        if (release_out) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++;
        if ({out_fp, out_ovf, out_unf, out_inexact} !== 35'd0) begin
            errors++; $display("FAIL reset_outputs got %h %b%b%b exp 0", out_fp, out_ovf, out_unf, out_inexact);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_aligned();
        run_op(1'b0, 10'd127, ONE48 << 48, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (r_to || r_fp !== 32'h3F800000 || r_inx !== 1'b0 || r_ovf !== 1'b0 || r_unf !== 1'b0) begin
            errors++; $display("FAIL aligned got %h inx %b to %b exp 3f800000 inx 0", r_fp, r_inx, r_to);
        end
        checks++;
        if (r_lat !== 3) begin errors++; $display("FAIL aligned_latency got %0d exp 3", r_lat); end
    endtask

    task automatic test_shift();
        run_op(1'b0, 10'd151, ONE48 << 24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (r_to || r_fp !== 32'h3F800000 || r_inx !== 1'b0) begin
            errors++; $display("FAIL shift got %h inx %b exp 3f800000 inx 0", r_fp, r_inx);
        end
        checks++;
        if (r_lat !== 27) begin errors++; $display("FAIL shift_latency got %0d exp 27", r_lat); end
        checks++;
        if (r_busy_ready !== 1'b0) begin errors++; $display("FAIL shift_in_ready got 1 exp 0"); end
        // 1.5 stored one place low: one shift, exponent 128 -> 3.0, sign set
        run_op(1'b1, 10'd129, (ONE48 << 47) | (ONE48 << 46), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (r_fp !== 32'hC0400000 || r_lat !== 4) begin
            errors++; $display("FAIL shift_one got %h lat %0d exp c0400000 lat 4", r_fp, r_lat);
        end
    endtask

    task automatic test_round();
        // Top 25 ones: frac all ones, guard 1 -> carry to 2.0
        run_op(1'b0, 10'd127, {25'h1FFFFFF, 24'd0}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (r_fp !== 32'h40000000 || r_inx !== 1'b1 || r_ovf !== 1'b0) begin
            errors++; $display("FAIL round_carry got %h inx %b exp 40000000 inx 1", r_fp, r_inx);
        end
        // Exact tie with even frac stays
        run_op(1'b0, 10'd127, (ONE48 << 48) | (ONE48 << 24), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (r_fp !== 32'h3F800000 || r_inx !== 1'b1) begin
            errors++; $display("FAIL round_tie_even got %h inx %b exp 3f800000 inx 1", r_fp, r_inx);
        end
        // Same tie but divider remainder nonzero -> round up
        run_op(1'b0, 10'd127, (ONE48 << 48) | (ONE48 << 24), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (r_fp !== 32'h3F800001 || r_inx !== 1'b1) begin
            errors++; $display("FAIL round_in_sticky got %h inx %b exp 3f800001 inx 1", r_fp, r_inx);
        end
        // Tie with odd frac -> round up to even
        run_op(1'b0, 10'd127, (ONE48 << 48) | (ONE48 << 25) | (ONE48 << 24), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (r_fp !== 32'h3F800002 || r_inx !== 1'b1) begin
            errors++; $display("FAIL round_tie_odd got %h inx %b exp 3f800002 inx 1", r_fp, r_inx);
        end
        // Guard 0, low sticky bit -> truncate, inexact
        run_op(1'b0, 10'd127, (ONE48 << 48) | (ONE48 << 25) | ONE48, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (r_fp !== 32'h3F800001 || r_inx !== 1'b1) begin
            errors++; $display("FAIL round_down got %h inx %b exp 3f800001 inx 1", r_fp, r_inx);
        end
    endtask

    task automatic test_ovf_unf();
        run_op(1'b0, 10'd255, ONE48 << 48, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (r_fp !== 32'h7F800000 || r_ovf !== 1'b1 || r_unf !== 1'b0 || r_inx !== 1'b1) begin
            errors++; $display("FAIL overflow got %h o%b u%b i%b exp 7f800000 o1 u0 i1", r_fp, r_ovf, r_unf, r_inx);
        end
        // Rounding carry pushes exponent 254 to 255
        run_op(1'b1, 10'd254, {25'h1FFFFFF, 24'd0}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (r_fp !== 32'hFF800000 || r_ovf !== 1'b1) begin
            errors++; $display("FAIL overflow_carry got %h ovf %b exp ff800000 ovf 1", r_fp, r_ovf);
        end
        run_op(1'b1, 10'd0, ONE48 << 48, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (r_fp !== 32'h80000000 || r_unf !== 1'b1 || r_ovf !== 1'b0 || r_inx !== 1'b0) begin
            errors++; $display("FAIL underflow got %h o%b u%b i%b exp 80000000 o0 u1 i0", r_fp, r_ovf, r_unf, r_inx);
        end
        // Exponent 1 becomes 0 after one normalising shift
        run_op(1'b0, 10'd1, ONE48 << 47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (r_fp !== 32'h00000000 || r_unf !== 1'b1) begin
            errors++; $display("FAIL underflow_shift got %h unf %b exp 00000000 unf 1", r_fp, r_unf);
        end
        // Exponent 1 that stays 1 is the smallest normal
        run_op(1'b0, 10'd1, ONE48 << 48, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (r_fp !== 32'h00800000 || r_unf !== 1'b0) begin
            errors++; $display("FAIL min_normal got %h unf %b exp 00800000 unf 0", r_fp, r_unf);
        end
    endtask

    task automatic test_specials();
        run_op(1'b1, 10'd127, ONE48 << 48, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (r_fp !== 32'h7FC00000 || r_lat !== 1 || {r_ovf, r_unf, r_inx} !== 3'b000) begin
            errors++; $display("FAIL special_nan got %h lat %0d exp 7fc00000 lat 1", r_fp, r_lat);
        end
        run_op(1'b1, 10'd127, ONE48 << 48, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (r_fp !== 32'h80000000 || r_lat !== 1 || {r_ovf, r_unf, r_inx} !== 3'b000) begin
            errors++; $display("FAIL special_zero got %h lat %0d exp 80000000 lat 1", r_fp, r_lat);
        end
        run_op(1'b1, 10'd3, ONE48 << 48, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (r_fp !== 32'hFF800000 || r_lat !== 1 || {r_ovf, r_unf, r_inx} !== 3'b000) begin
            errors++; $display("FAIL special_inf got %h lat %0d exp ff800000 lat 1", r_fp, r_lat);
        end
        run_op(1'b0, 10'd127, 49'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (r_fp !== 32'h00000000 || r_lat !== 1) begin
            errors++; $display("FAIL special_mant_zero got %h lat %0d exp 00000000 lat 1", r_fp, r_lat);
        end
    endtask

    task automatic test_backpressure();
        logic stable, busy;
        run_op(1'b1, 10'd128, (ONE48 << 48) | (ONE48 << 47), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (r_fp !== 32'hC0400000) begin errors++; $display("FAIL bp_value got %h exp c0400000", r_fp); end
        stable = 1'b1;
        busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_fp !== r_fp || out_valid !== 1'b1) stable = 1'b0;
            if (in_ready !== 1'b0) busy = 1'b1;
        end
        checks++;
        if (stable !== 1'b1) begin errors++; $display("FAIL bp_stable got %h valid %b exp c0400000 valid 1", out_fp, out_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_in_ready got 1 exp 0"); end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL out_cycle_in_ready got %b exp 0", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got valid %b ready %b exp 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_norm();
        logic seen;
        in_sign = 1'b0; in_exp = 10'd151; in_mant = ONE48 << 24; in_sticky = 1'b0;
        in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_output got 1 exp 0"); end
        run_op(1'b0, 10'd128, (ONE48 << 47) | (ONE48 << 46), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (r_fp !== 32'h3FC00000 || r_lat !== 4) begin
            errors++; $display("FAIL after_reset got %h lat %0d exp 3fc00000 lat 4", r_fp, r_lat);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_sign = 1'b0; in_exp = 10'd0; in_mant = 49'd0; in_sticky = 1'b0;
        in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0;
        test_reset();
        test_aligned();
        test_shift();
        test_round();
        test_ovf_unf();
        test_specials();
        test_backpressure();
        test_reset_mid_norm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
